// File: rtl/id_operand_reader_pkg.sv
// Shared decode definitions for the ID operand reader: opcodes, the tracked
// register set and its mapping onto the flat register bus.
package id_operand_reader_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [4:0] REG_T0 = 5'd8;
    localparam logic [4:0] REG_T1 = 5'd9;
    localparam logic [4:0] REG_T2 = 5'd10;
    localparam logic [4:0] REG_T3 = 5'd11;
    localparam logic [4:0] REG_T4 = 5'd12;
    localparam logic [4:0] REG_T5 = 5'd13;
    localparam logic [4:0] REG_S0 = 5'd16;
    localparam logic [4:0] REG_S1 = 5'd17;
    localparam logic [4:0] REG_S2 = 5'd18;
    localparam logic [4:0] REG_S3 = 5'd19;
    localparam logic [4:0] REG_S4 = 5'd20;
    localparam logic [4:0] REG_S5 = 5'd21;

    localparam int NUM_TRACKED = 12;

    // Position in this table is the slice number k on the register bus.
    localparam logic [4:0] TRACKED_IDX [NUM_TRACKED] = '{
        REG_T0, REG_T1, REG_T2, REG_T3, REG_T4, REG_T5,
        REG_S0, REG_S1, REG_S2, REG_S3, REG_S4, REG_S5
    };

    typedef struct packed {
        logic       uses_rs;
        logic       uses_rt;
        logic       has_dest;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dest;
    } decode_t;

    function automatic logic is_tracked(input logic [4:0] idx);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_TRACKED; i++) begin
            if (TRACKED_IDX[i] == idx) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic logic [3:0] reg_slice(input logic [4:0] idx);
        logic [3:0] k;
        k = '0;
        for (int i = 0; i < NUM_TRACKED; i++) begin
            if (TRACKED_IDX[i] == idx) k = 4'(i);
        end
        return k;
    endfunction

    function automatic decode_t decode(input logic [31:0] instr);
        decode_t d;
        d    = '0;
        d.rs = instr[25:21];
        d.rt = instr[20:16];
        case (instr[31:26])
            OP_RTYPE: begin
                d.uses_rs  = 1'b1;
                d.uses_rt  = 1'b1;
                d.has_dest = 1'b1;
                d.dest     = instr[15:11];
            end
            OP_LW, OP_ADDI: begin
                d.uses_rs  = 1'b1;
                d.has_dest = 1'b1;
                d.dest     = instr[20:16];
            end
            OP_SW, OP_BEQ: begin
                d.uses_rs = 1'b1;
                d.uses_rt = 1'b1;
            end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/id_operand_reader_if.sv
// IF->ID instruction handshake and ID->EX operand bundle handshake.
interface id_operand_reader_if #(
    parameter int DATA_W = 32
) ();
    logic [31:0]       if_instruction;
    logic              if_valid;
    logic              if_ready;
    logic              id_valid;
    logic              ex_ready;
    logic [31:0]       id_instruction;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm_ext;
    logic [4:0]        id_dest;

    modport master (
        input  if_instruction, if_valid, ex_ready,
        output if_ready, id_valid, id_instruction, rs_data, rt_data, imm_ext, id_dest
    );

    modport slave (
        output if_instruction, if_valid, ex_ready,
        input  if_ready, id_valid, id_instruction, rs_data, rt_data, imm_ext, id_dest
    );
endinterface

// File: rtl/id_operand_reader_reg_scoreboard.sv
// Per-register saturating count of issued-but-not-retired writes, with
// operand-ready and destination-saturated queries.
module reg_scoreboard
    import id_operand_reader_pkg::*;
#(
    parameter int PEND_W = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc_i,
    input  logic [4:0] inc_idx_i,
    input  logic       dec_i,
    input  logic [4:0] dec_idx_i,
    input  logic [4:0] rs_idx_i,
    input  logic [4:0] rt_idx_i,
    input  logic [4:0] dst_idx_i,
    output logic       rs_ready_o,
    output logic       rt_ready_o,
    output logic       dst_sat_o
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    logic [PEND_W-1:0]      pend_q [NUM_TRACKED];
    logic [PEND_W-1:0]      pend_d [NUM_TRACKED];
    logic [NUM_TRACKED-1:0] inc_hit;
    logic [NUM_TRACKED-1:0] dec_hit;
    logic                   dec_at_zero;

    function automatic logic [PEND_W-1:0] pend_of(input logic [4:0] idx);
        return is_tracked(idx) ? pend_q[reg_slice(idx)] : '0;
    endfunction

    // A write retiring this cycle already shows on the bus, so the last
    // outstanding write to a source does not block it.
    function automatic logic src_ready(input logic [4:0] idx);
        return (pend_of(idx) == '0) ||
               ((pend_of(idx) == PEND_ONE) && dec_i && (dec_idx_i == idx));
    endfunction

    always_comb begin
        inc_hit = '0;
        dec_hit = '0;
        for (int k = 0; k < NUM_TRACKED; k++) begin
            pend_d[k]  = pend_q[k];
            inc_hit[k] = inc_i && is_tracked(inc_idx_i) && (reg_slice(inc_idx_i) == 4'(k));
            dec_hit[k] = dec_i && is_tracked(dec_idx_i) && (reg_slice(dec_idx_i) == 4'(k));
            if (inc_hit[k] && !dec_hit[k] && (pend_q[k] != PEND_MAX)) begin
                pend_d[k] = pend_q[k] + PEND_ONE;
            end else if (dec_hit[k] && !inc_hit[k] && (pend_q[k] != '0)) begin
                pend_d[k] = pend_q[k] - PEND_ONE;
            end
        end
    end

    // NOTE: the counters are individual flops, not a RAM, so an async clear of
    // every entry is cheap and drops all hazard history at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_TRACKED; k++) pend_q[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_TRACKED; k++) pend_q[k] <= pend_d[k];
        end
    end

    assign rs_ready_o = src_ready(rs_idx_i);
    assign rt_ready_o = src_ready(rt_idx_i);
    assign dst_sat_o  = is_tracked(dst_idx_i) && (pend_of(dst_idx_i) == PEND_MAX);

    assign dec_at_zero = dec_i && is_tracked(dec_idx_i) && (pend_of(dec_idx_i) == '0);

    a_no_dec_at_zero: assert property (@(posedge clk) disable iff (!rst) !dec_at_zero);

endmodule

// File: rtl/id_operand_reader.sv
// Decode/operand-fetch stage: classifies the incoming instruction, stalls on
// RAW and scoreboard-full hazards, and registers the operand bundle for EX.
module id_operand_reader
    import id_operand_reader_pkg::*;
#(
    parameter int PEND_W = 2,
    parameter int DATA_W = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_TRACKED*DATA_W-1:0] regs_flat,
    input  logic                          wb_valid,
    input  logic [4:0]                    wb_rd,
    id_operand_reader_if.master           bus
);

    decode_t           dec;
    logic              rs_ready;
    logic              rt_ready;
    logic              dst_sat;
    logic              stall;
    logic              out_free;
    logic              issue;
    logic [DATA_W-1:0] rs_data_d;
    logic [DATA_W-1:0] rt_data_d;
    logic [DATA_W-1:0] imm_ext_d;

    logic              id_valid_q;
    logic [31:0]       id_instruction_q;
    logic [DATA_W-1:0] rs_data_q;
    logic [DATA_W-1:0] rt_data_q;
    logic [DATA_W-1:0] imm_ext_q;
    logic [4:0]        id_dest_q;

    assign dec = decode(bus.if_instruction);

    reg_scoreboard #(
        .PEND_W (PEND_W)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .inc_i      (issue && dec.has_dest),
        .inc_idx_i  (dec.dest),
        .dec_i      (wb_valid),
        .dec_idx_i  (wb_rd),
        .rs_idx_i   (dec.rs),
        .rt_idx_i   (dec.rt),
        .dst_idx_i  (dec.dest),
        .rs_ready_o (rs_ready),
        .rt_ready_o (rt_ready),
        .dst_sat_o  (dst_sat)
    );

    assign stall    = (dec.uses_rs && !rs_ready) ||
                      (dec.uses_rt && !rt_ready) ||
                      (dec.has_dest && dst_sat);
    assign out_free = !id_valid_q || bus.ex_ready;
    assign issue    = bus.if_valid && out_free && !stall;

    // NOTE: each always_comb output is given a default before any branch so
    // no path leaves it unassigned and infers a latch.
    always_comb begin
        rs_data_d = '0;
        rt_data_d = '0;
        if (dec.uses_rs && is_tracked(dec.rs)) begin
            rs_data_d = regs_flat[reg_slice(dec.rs)*DATA_W +: DATA_W];
        end
        if (dec.uses_rt && is_tracked(dec.rt)) begin
            rt_data_d = regs_flat[reg_slice(dec.rt)*DATA_W +: DATA_W];
        end
        imm_ext_d = {{(DATA_W-16){bus.if_instruction[15]}}, bus.if_instruction[15:0]};
    end

    // NOTE: state is written with <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_valid_q       <= 1'b0;
            id_instruction_q <= '0;
            rs_data_q        <= '0;
            rt_data_q        <= '0;
            imm_ext_q        <= '0;
            id_dest_q        <= '0;
        end else if (issue) begin
            id_valid_q       <= 1'b1;
            id_instruction_q <= bus.if_instruction;
            rs_data_q        <= rs_data_d;
            rt_data_q        <= rt_data_d;
            imm_ext_q        <= imm_ext_d;
            id_dest_q        <= dec.dest;
        end else if (bus.ex_ready) begin
            id_valid_q       <= 1'b0;
        end
    end

    assign bus.if_ready       = out_free && !stall;
    assign bus.id_valid       = id_valid_q;
    assign bus.id_instruction = id_instruction_q;
    assign bus.rs_data        = rs_data_q;
    assign bus.rt_data        = rt_data_q;
    assign bus.imm_ext        = imm_ext_q;
    assign bus.id_dest        = id_dest_q;

endmodule

// File: doc/id_operand_reader.md
Name: id_operand_reader

Overview:
- Decode/operand-fetch stage: the read side of the architectural register file that the write-back stage updates on negedge clk.
- Accepts one instruction per cycle from IF, classifies it, and reads source operands from the register bus.
- Tracks outstanding writes in a per-register scoreboard and stalls on RAW hazards.
- Issues a registered operand bundle to EX with a valid/ready handshake.

Parameters:
- PEND_W, 2, width of each per-register pending-write counter (saturating; max outstanding writes per register = 2^PEND_W-1).
- DATA_W, 32, register/operand width.

Ports:
- clk  in  1  clock, rising edge for all state in this block
- rst  in  1  reset; asynchronous, active-low
- if_instruction  in  32  instruction from IF
- if_valid  in  1  if_instruction valid
- if_ready  out  1  block accepts if_instruction this cycle (combinational)
- regs_flat  in  384  architectural regs; slice k = [32k+31:32k], k0..5 = t0..t5 (idx 8..13), k6..11 = s0..s5 (idx 16..21)
- wb_valid  in  1  WB retired a register write this cycle
- wb_rd  in  5  destination index of that write
- id_valid  out  1  output bundle valid
- ex_ready  in  1  EX accepts bundle
- id_instruction  out  32  issued instruction
- rs_data  out  32  operand A
- rt_data  out  32  operand B
- imm_ext  out  32  sign-extended instruction[15:0]
- id_dest  out  5  destination index, 0 if none

Behaviour:
- Reset (rst=0, async): id_valid=0; id_instruction, rs_data, rt_data, imm_ext=0; id_dest=0; all pending counters=0.
- Index map: 8..13 -> t0..t5; 16..21 -> s0..s5. Any other index reads 0, is never tracked and never stalls.
- Classification by opcode [31:26]:
  - 000000 R-type: srcs rs[25:21], rt[20:16]; dest rd[15:11].
  - 100011 lw, 001000 addi: src rs; dest rt.
  - 101011 sw, 000100 beq: srcs rs, rt; no dest.
  - Other opcodes: no srcs, no dest; pass through as nop.
- Source ready: pending[src]==0, or (pending[src]==1 && wb_valid && wb_rd==src). WB writes the register on the preceding negedge, so the bus value is already current.
- Stall conditions: any used src not ready, or dest tracked and pending[dest] saturated.
- Handshake:
  - out_free = !id_valid || ex_ready.
  - if_ready = out_free && !stall.
  - issue = if_valid && if_ready.
- On issue (posedge): capture id_instruction, rs_data, rt_data (unused src -> 0), imm_ext, id_dest; id_valid<=1.
- No issue but ex_ready && id_valid: id_valid<=0; data regs hold.
- id_valid && !ex_ready: all outputs hold.
- Latency: 1 cycle from accepted if_instruction to id_valid.
- Scoreboard update per tracked reg r, each posedge: pending[r] += (issue && dest==r) - (wb_valid && wb_rd==r).
  - Simultaneous inc and dec on the same reg: net no change.
  - Decrement at 0 is ignored and must never occur in legal traffic; flag with an assertion.
- Reset mid-operation: bundle dropped, scoreboard cleared; the owner resets WB and upstream together.

Decomposition:
- Shared package: opcode constants (OP_RTYPE, OP_LW, OP_ADDI, OP_SW, OP_BEQ), register index constants (REG_T0..REG_S5), regs_flat slice function idx->k.
- Sub-module: reg_scoreboard (counters, inc/dec ports, ready/saturated query for up to 3 indices).

Test Plan:
- Reset with regs_flat = t0..t5 = 1..6, s0..s5 = 4,8..12; send add $t2,$t0,$s1 (0x01115020) -> next cycle id_valid=1, rs_data=1, rt_data=8, id_dest=10.
- Back-to-back addi $t0,$t0,5 then add $t1,$t0,$t0 -> second instruction stalled (if_ready=0) until wb_valid with wb_rd=8. It issues that same cycle and reads the updated regs_flat value.
- Three outstanding writes to $s0 with PEND_W=2 -> third accepted, fourth writer stalled until a wb_valid with wb_rd=16.
- ex_ready=0 for 3 cycles with id_valid=1 -> outputs stable, if_ready=0; ex_ready=1 -> next instruction issues the same cycle.
- lw $t3,-4($s2) -> imm_ext=0xFFFFFFFC, rs_data=9, id_dest=11; sw $t3,0($s2) stalls until WB of index 11.
- Assert rst mid-stream with pending counters non-zero -> id_valid=0 immediately, counters 0, next instruction issues with no stall.
